// File: rtl/trace_arb_pkg.sv
// Shared types and helpers for the trace issue arbiter.
// Holds the issue FSM state encoding, the default counter width and a
// saturating increment used for the issue and timeout counters.
package trace_arb_pkg;

  localparam int unsigned CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/trace_issue_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr_i, wrapping modulo N (N must be a power of 2).
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Scan from the farthest candidate back to ptr_i so the nearest one wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr_i + IW'(N - 1 - k);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/trace_issue_arbiter.sv
// Round-robin arbiter and issue sequencer sharing one cache hierarchy
// between NUM_CORES trace requesters: grant, issue strobe, wait for a
// rising edge on updated, acknowledge the granted core.
// Optional WAIT watchdog enabled by defining TRACE_ARB_TIMEOUT_EN.
module trace_issue_arbiter #(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned CNT_W          = trace_arb_pkg::CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IDW           = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        req_done,
  output logic                        req_err,
  output logic                        trace_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        updated,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy,
  output logic [CNT_W-1:0]            issue_count,
  output logic [CNT_W-1:0]            timeout_count
);
  import trace_arb_pkg::*;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             upd_q;
  logic             upd_edge;
  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;

`ifdef TRACE_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
`endif

  rr_picker #(.N(NUM_CORES), .IW(IDW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // upd_q follows updated every cycle, so a level that is already high
  // when WAIT is entered never looks like a fresh completion.
  assign upd_edge = updated & ~upd_q;

  // Next-state and datapath updates for the issue sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
`ifdef TRACE_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue_cnt_d = sat_inc(issue_cnt_q);
        state_d     = WAIT;
`ifdef TRACE_ARB_TIMEOUT_EN
        wait_cnt_d  = '0;
        err_d       = 1'b0;
`endif
      end
      WAIT: begin
        // The completion edge takes priority over a simultaneous timeout.
        if (upd_edge) begin
          state_d = ACK;
`ifdef TRACE_ARB_TIMEOUT_EN
        end else if (wait_cnt_q == TO_LAST) begin
          state_d   = ACK;
          err_d     = 1'b1;
          tmo_cnt_d = sat_inc(tmo_cnt_q);
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
        end
      end
      ACK: begin
        rr_ptr_d = grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All sequential state; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      upd_q       <= 1'b0;
`ifdef TRACE_ARB_TIMEOUT_EN
      wait_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      upd_q       <= updated;
`ifdef TRACE_ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    trace_ready = (state_q == ISSUE);
    busy        = (state_q != IDLE);
    req_done    = (state_q == ACK) ? (NUM_CORES'(1) << grant_q) : '0;
    mem_addr    = addr_q;
    grant_id    = grant_q;
    issue_count = issue_cnt_q;
`ifdef TRACE_ARB_TIMEOUT_EN
    req_err       = (state_q == ACK) & err_q;
    timeout_count = tmo_cnt_q;
`else
    req_err       = 1'b0;
    timeout_count = '0;
`endif
  end

endmodule
